// File: rtl/fp_div_core_if.sv
// Handshake/data bundle between a requester and fp_div_core.
//   master: drives start, a, b; observes busy, out_valid and the result fields.
//   slave : the divider side of the same signals.
// Result fields (sign/exp/sig plus per-operand class flags) match what the
// division pack stage consumes.
interface fp_div_core_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned SIG_W = 23
);
  logic                   start;
  logic [EXP_W+SIG_W:0]   a;
  logic [EXP_W+SIG_W:0]   b;
  logic                   busy;
  logic                   out_valid;
  logic                   sign;
  logic [EXP_W-1:0]       exp;
  logic [SIG_W-1:0]       sig;
  logic                   a_zero;
  logic                   a_infinity;
  logic                   a_NAN;
  logic                   b_zero;
  logic                   b_infinity;
  logic                   b_NAN;

  modport master (
    output start, a, b,
    input  busy, out_valid, sign, exp, sig,
    input  a_zero, a_infinity, a_NAN, b_zero, b_infinity, b_NAN
  );

  modport slave (
    input  start, a, b,
    output busy, out_valid, sign, exp, sig,
    output a_zero, a_infinity, a_NAN, b_zero, b_infinity, b_NAN
  );
endinterface

// File: rtl/fp_div_core.sv
// Sequential single-precision divider core (mantissa/exponent path only).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any operation in flight
//   bus   - fp_div_core_if.slave: start/a/b request in, busy/out_valid and
//           sign/exp/sig plus a_/b_ zero/infinity/NAN class flags out
// Operation: operands are classified and latched when start is seen in IDLE.
// Normal operands run 25 restoring radix-2 steps (DIV), then one NORM cycle
// normalizes/truncates and saturates exponent overflow/underflow, then DONE
// pulses out_valid. Operands with any class flag set skip DIV.
module fp_div_core #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned SIG_W = 23,
  parameter int unsigned BIAS  = 127
) (
  input logic           clk,
  input logic           rst_n,
  fp_div_core_if.slave  bus
);

  localparam int unsigned W  = 1 + EXP_W + SIG_W;  // operand width
  localparam int unsigned MW = SIG_W + 1;          // mantissa with hidden bit
  localparam int unsigned QW = SIG_W + 2;          // quotient / remainder width
  localparam int unsigned EW = EXP_W + 2;          // signed exponent arithmetic
  localparam int unsigned CW = $clog2(QW);

  localparam logic signed [EW-1:0] BiasS = EW'(BIAS);
  localparam logic signed [EW-1:0] EMax  = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
  logic [MW-1:0]     mb_q, mb_d;
  logic [QW-1:0]     r_q, r_d;
  logic [QW-1:0]     q_q, q_d;
  logic              special_q, special_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  // {zero, infinity, nan}
  logic [2:0]        fa_q, fa_d, fb_q, fb_d;

  logic [2:0]              cls_a, cls_b;
  logic signed [EW-1:0]    e_raw, e_fin;
  logic [QW-1:0]           mb_ext;

  function automatic logic [2:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
    e = x[W-2:SIG_W];
    f = x[SIG_W-1:0];
    // Denormals are flushed to zero.
    return {e == '0, (&e) && (f == '0), (&e) && (f != '0)};
  endfunction

  assign cls_a  = classify(bus.a);
  assign cls_b  = classify(bus.b);
  assign mb_ext = {1'b0, mb_q};

  // Result exponent before and after the normalization adjustment.
  assign e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BiasS;
  assign e_fin = q_q[QW-1] ? e_raw : e_raw - EW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    mb_d      = mb_q;
    r_d       = r_q;
    q_d       = q_q;
    special_d = special_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    sig_d     = sig_q;
    fa_d      = fa_q;
    fb_d      = fb_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sign_d    = bus.a[W-1] ^ bus.b[W-1];
          fa_d      = cls_a;
          fb_d      = cls_b;
          special_d = (|cls_a) || (|cls_b);
          ea_d      = bus.a[W-2:SIG_W];
          eb_d      = bus.b[W-2:SIG_W];
          mb_d      = {1'b1, bus.b[SIG_W-1:0]};
          r_d       = {1'b0, 1'b1, bus.a[SIG_W-1:0]};
          q_d       = '0;
          cnt_d     = CW'(QW - 1);
          // Special operands take one pass-through cycle in NORM so that
          // out_valid lands on the second cycle after acceptance.
          state_d   = special_d ? StNorm : StDiv;
        end
      end
      StDiv: begin
        if (r_q >= mb_ext) begin
          q_d = {q_q[QW-2:0], 1'b1};
          r_d = (r_q - mb_ext) << 1;
        end else begin
          q_d = {q_q[QW-2:0], 1'b0};
          r_d = r_q << 1;
        end
        if (cnt_q == '0) begin
          state_d = StNorm;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StNorm: begin
        // exp/sig are don't-care for special operands; leave them untouched.
        if (!special_q) begin
          if (e_fin >= EMax) begin
            exp_d = '1;
            sig_d = '0;
          end else if (e_fin <= 0) begin
            exp_d = '0;
            sig_d = '0;
          end else begin
            exp_d = e_fin[EXP_W-1:0];
            sig_d = q_q[QW-1] ? q_q[QW-2:1] : q_q[QW-3:0];
          end
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ea_q      <= '0;
      eb_q      <= '0;
      mb_q      <= '0;
      r_q       <= '0;
      q_q       <= '0;
      special_q <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      sig_q     <= '0;
      fa_q      <= '0;
      fb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      mb_q      <= mb_d;
      r_q       <= r_d;
      q_q       <= q_d;
      special_q <= special_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      sig_q     <= sig_d;
      fa_q      <= fa_d;
      fb_q      <= fb_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.sign       = sign_q;
  assign bus.exp        = exp_q;
  assign bus.sig        = sig_q;
  assign bus.a_zero     = fa_q[2];
  assign bus.a_infinity = fa_q[1];
  assign bus.a_NAN      = fa_q[0];
  assign bus.b_zero     = fb_q[2];
  assign bus.b_infinity = fb_q[1];
  assign bus.b_NAN      = fb_q[0];

endmodule

// File: tb/tb_fp_div_core.sv
// Scoreboard bench for fp_div_core: the driver pushes hand-computed expected
// results, a negedge monitor pops and compares whenever out_valid is high.
module tb_fp_div_core;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  fp_div_core_if #(.EXP_W(8), .SIG_W(23)) bus ();

  fp_div_core #(.EXP_W(8), .SIG_W(23), .BIAS(127)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] sig;
    logic [5:0]  flags;   // {a_zero, a_inf, a_nan, b_zero, b_inf, b_nan}
    logic        chk_es;  // exp/sig meaningful
    int          cyc;     // cycle count at which out_valid must be seen
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      logic [5:0] fl;
      exp_t e;
      fl = {bus.a_zero, bus.a_infinity, bus.a_NAN, bus.b_zero, bus.b_infinity, bus.b_NAN};
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL latency: out_valid at cycle %0d, required %0d", cyc, e.cyc);
        end
        n_cmp++;
        if (bus.sign != e.sign || fl != e.flags) begin
          n_fail++;
          $display("FAIL sign_flags: got sign=%0b flags=%06b, required sign=%0b flags=%06b",
                   bus.sign, fl, e.sign, e.flags);
        end
        if (e.chk_es) begin
          n_cmp++;
          if (bus.exp != e.exp || bus.sig != e.sig) begin
            n_fail++;
            $display("FAIL exp_sig: got exp=%02h sig=%06h, required exp=%02h sig=%06h",
                     bus.exp, bus.sig, e.exp, e.sig);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Pulse start for one cycle; optionally push the expected result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic push,
                       input logic sign, input logic [7:0] ex, input logic [22:0] sg,
                       input logic [5:0] flags, input logic chk_es, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h1234_5678;
    if (push) begin
      e.sign   = sign;
      e.exp    = ex;
      e.sig    = sg;
      e.flags  = flags;
      e.chk_es = chk_es;
      e.cyc    = cyc + lat - 1;
      sb.push_back(e);
    end
  endtask

  // Wait for out_valid with busy held high; then busy must fall.
  task automatic wait_done(input string name);
    bit seen;
    bit busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_busy_held"}, 64'(busy_ok), 64'd1);
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid=0 after 40 cycles, required 1", name);
    end
    @(negedge clk);
    #1;
    check({name, "_busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("reset_outputs",
          64'({bus.busy, bus.out_valid, bus.sign, bus.exp, bus.sig, bus.a_zero, bus.a_infinity,
               bus.a_NAN, bus.b_zero, bus.b_infinity, bus.b_NAN}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 6.0 / 2.0 = 3.0
    issue(32'h40C0_0000, 32'h4000_0000, 1, 0, 8'h80, 23'h40_0000, 6'b000000, 1, 27);
    wait_done("six_div_two");
    // 1.0 / 3.0, truncated
    issue(32'h3F80_0000, 32'h4040_0000, 1, 0, 8'h7D, 23'h2A_AAAA, 6'b000000, 1, 27);
    wait_done("one_third");
    // -6.0 / 2.0
    issue(32'hC0C0_0000, 32'h4000_0000, 1, 1, 8'h80, 23'h40_0000, 6'b000000, 1, 27);
    wait_done("neg_six_div_two");
    // Specials
    issue(32'h7F80_0000, 32'h3F80_0000, 1, 0, 8'h00, 23'h0, 6'b010000, 0, 2);
    wait_done("a_inf");
    issue(32'h7FC0_0000, 32'h3F80_0000, 1, 0, 8'h00, 23'h0, 6'b001000, 0, 2);
    wait_done("a_nan");
    issue(32'h3F80_0000, 32'h0000_0000, 1, 0, 8'h00, 23'h0, 6'b000100, 0, 2);
    wait_done("b_zero");
    issue(32'h0000_0000, 32'h3F80_0000, 1, 0, 8'h00, 23'h0, 6'b100000, 0, 2);
    wait_done("a_zero");
    issue(32'h3F80_0000, 32'hFF80_0000, 1, 1, 8'h00, 23'h0, 6'b000010, 0, 2);
    wait_done("b_inf");
    issue(32'h3F80_0000, 32'h7F80_0001, 1, 0, 8'h00, 23'h0, 6'b000001, 0, 2);
    wait_done("b_nan");
    // Overflow / underflow
    issue(32'h7F00_0000, 32'h0080_0000, 1, 0, 8'hFF, 23'h0, 6'b000000, 1, 27);
    wait_done("overflow");
    issue(32'h0080_0000, 32'h7F00_0000, 1, 0, 8'h00, 23'h0, 6'b000000, 1, 27);
    wait_done("underflow");

    // Second start mid-DIV is ignored.
    issue(32'h40C0_0000, 32'h4000_0000, 1, 0, 8'h80, 23'h40_0000, 6'b000000, 1, 27);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h3F80_0000;
    bus.b     = 32'h0000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_while_busy");

    // Reset mid-DIV discards the operation.
    issue(32'hC0C0_0000, 32'h4040_0000, 0, 0, 8'h00, 23'h0, 6'b000000, 0, 27);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs",
          64'({bus.busy, bus.out_valid, bus.sign, bus.exp, bus.sig, bus.a_zero, bus.a_infinity,
               bus.a_NAN, bus.b_zero, bus.b_infinity, bus.b_NAN}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("no_valid_after_reset", 64'(bus.busy), 64'd0);
    issue(32'h3F80_0000, 32'h4040_0000, 1, 0, 8'h7D, 23'h2A_AAAA, 6'b000000, 1, 27);
    wait_done("after_reset");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
